// File: rtl/morse_pkg.sv
// morse_pkg: shared states, widths and token type for the Morse symbol decoder.
package morse_pkg;
   localparam int MORSE_MAX_SYMBOLS = 5;
   localparam int CODE_W = 5;
   localparam int LEN_W = 3;
   typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD} state_t;
   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [LEN_W-1:0] len;
      logic space;
      logic err;
   } token_t;
endpackage

// File: rtl/morse_symbol_decoder_if.sv
// morse_symbol_decoder_if: valid/ready token channel from the decoder to its consumer.
interface morse_symbol_decoder_if;
   import morse_pkg::*;
   logic sym_valid;
   logic sym_ready;
   logic [CODE_W-1:0] sym_code;
   logic [LEN_W-1:0] sym_len;
   logic sym_space;
   logic sym_err;
   modport master(output sym_valid, sym_code, sym_len, sym_space, sym_err, input sym_ready);
   modport slave(input sym_valid, sym_code, sym_len, sym_space, sym_err, output sym_ready);
endinterface

// File: rtl/morse_tick_gen.sv
// morse_tick_gen: one-cycle tick every TICK_CYCLES clocks; restart realigns the prescaler.
module morse_tick_gen #(
   parameter int TICK_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam int W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (reset || restart) cnt <= '0;
      else cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
   assign tick = !restart && cnt == LAST;
endmodule

// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder: turns key press/release edges into Morse letter tokens.
// Define MORSE_WORD_SPACE_EN to emit a space token after a word gap.
module morse_symbol_decoder
   import morse_pkg::*;
#(
   parameter int TICK_CYCLES = 50000,
   parameter int DOT_MAX_TICKS = 200,
   parameter int LETTER_GAP_TICKS = 400,
   parameter int WORD_GAP_TICKS = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic p_edge,
   input  logic n_edge,
   morse_symbol_decoder_if.master sym,
   output logic overrun
);
   localparam int DUR_W = $clog2(WORD_GAP_TICKS + 1);
   localparam logic [DUR_W-1:0] DOT_MAX = DUR_W'(DOT_MAX_TICKS);
   localparam logic [DUR_W-1:0] LETTER_GAP = DUR_W'(LETTER_GAP_TICKS);
   localparam logic [DUR_W-1:0] WORD_GAP = DUR_W'(WORD_GAP_TICKS);
   state_t state, state_nx;
   logic [DUR_W-1:0] dur;
   logic [CODE_W-1:0] code, code_nx;
   logic [LEN_W-1:0] len, len_nx;
   logic err, err_nx, restart, tick, emit;
   token_t tok, tok_q;

   morse_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk(clk), .reset(reset), .restart(restart), .tick(tick)
   );

   always_comb begin
      state_nx = state;
      code_nx = code;
      len_nx = len;
      err_nx = err;
      restart = 1'b0;
      emit = 1'b0;
      tok = '0;
      case (state)
         IDLE, WORD: begin
            if (p_edge) begin
               state_nx = PRESS;
               code_nx = '0;
               len_nx = '0;
               err_nx = 1'b0;
               restart = 1'b1;
            end else if (state == WORD && dur == WORD_GAP) begin
               state_nx = IDLE;
`ifdef MORSE_WORD_SPACE_EN
               emit = 1'b1;
               tok.space = 1'b1;
`endif
            end
         end
         PRESS: begin
            if (n_edge) begin
               state_nx = GAP;
               restart = 1'b1;
               if (len == LEN_W'(MORSE_MAX_SYMBOLS)) err_nx = 1'b1;
               else begin
                  code_nx = {code[CODE_W-2:0], dur >= DOT_MAX};
                  len_nx = len + LEN_W'(1);
               end
            end
         end
         GAP: begin
            if (p_edge) begin
               state_nx = PRESS;
               restart = 1'b1;
            end else if (dur == LETTER_GAP) begin
               state_nx = WORD;
               emit = 1'b1;
               tok = '{code, len, 1'b0, err};
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         dur <= '0;
         code <= '0;
         len <= '0;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         code <= code_nx;
         len <= len_nx;
         err <= err_nx;
         if (restart) dur <= '0;
         else if (tick && dur != WORD_GAP) dur <= dur + DUR_W'(1);
      end
   end

   // An emit into an occupied, stalled output is dropped; the FSM has already moved on.
   always_ff @(posedge clk) begin
      if (reset) begin
         sym.sym_valid <= 1'b0;
         tok_q <= '0;
         overrun <= 1'b0;
      end else if (emit && sym.sym_valid && !sym.sym_ready) begin
         overrun <= 1'b1;
      end else if (emit) begin
         sym.sym_valid <= 1'b1;
         tok_q <= tok;
      end else if (sym.sym_ready) begin
         sym.sym_valid <= 1'b0;
      end
   end

   assign sym.sym_code = tok_q.code;
   assign sym.sym_len = tok_q.len;
   assign sym.sym_space = tok_q.space;
   assign sym.sym_err = tok_q.err;
endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb_morse_symbol_decoder: directed letter/space/overrun/reset scenarios with fixed expectations.
module tb_morse_symbol_decoder;
   import morse_pkg::*;
   localparam int TK = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic p_edge = 1'b0;
   logic n_edge = 1'b0;
   logic overrun;
   int tests = 0;
   int fails = 0;
   token_t q[$];

   morse_symbol_decoder_if bus();

   morse_symbol_decoder #(
      .TICK_CYCLES(TK), .DOT_MAX_TICKS(3), .LETTER_GAP_TICKS(3), .WORD_GAP_TICKS(7)
   ) dut (
      .clk(clk), .reset(reset), .p_edge(p_edge), .n_edge(n_edge), .sym(bus), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!reset && bus.sym_valid && bus.sym_ready)
         q.push_back('{bus.sym_code, bus.sym_len, bus.sym_space, bus.sym_err});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int k);
      cyc(k * TK);
   endtask

   task automatic key_down();
      p_edge = 1'b1;
      cyc(1);
      p_edge = 1'b0;
   endtask

   task automatic key_up();
      n_edge = 1'b1;
      cyc(1);
      n_edge = 1'b0;
   endtask

   task automatic press(input int k);
      key_down();
      ticks(k);
      key_up();
   endtask

   task automatic take(input string tag, input logic [4:0] c, input logic [2:0] l,
                       input logic s, input logic e);
      token_t t;
      check({tag, "_avail"}, 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
         t = q.pop_front();
         check({tag, "_code"}, 32'(t.code), 32'(c));
         check({tag, "_len"}, 32'(t.len), 32'(l));
         check({tag, "_space"}, 32'(t.space), 32'(s));
         check({tag, "_err"}, 32'(t.err), 32'(e));
      end
   endtask

   task automatic end_word(input string tag);
`ifdef MORSE_WORD_SPACE_EN
      take({tag, "_sp"}, 5'd0, 3'd0, 1'b1, 1'b0);
`endif
      check({tag, "_left"}, 32'(q.size()), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(bus.sym_valid), 0);
      check({tag, "_code"}, 32'(bus.sym_code), 0);
      check({tag, "_len"}, 32'(bus.sym_len), 0);
      check({tag, "_space"}, 32'(bus.sym_space), 0);
      check({tag, "_err"}, 32'(bus.sym_err), 0);
      check({tag, "_ovr"}, 32'(overrun), 0);
   endtask

   initial begin
      bus.sym_ready = 1'b1;
      cyc(3);
      check_reset_outputs("rst");
      reset = 1'b0;
      cyc(2);
      // 'A': dot, dash, then a long release that closes letter and word
      press(2);
      ticks(1);
      press(5);
      ticks(15);
      take("A", 5'b00001, 3'd2, 1'b0, 1'b0);
      end_word("A");
      // six dots: the sixth is flagged, not stored
      for (int i = 0; i < 6; i++) begin
         press(1);
         ticks(1);
      end
      ticks(12);
      take("six", 5'b00000, 3'd5, 1'b0, 1'b1);
      end_word("six");
      // 3 ticks is a dash, 2 ticks is a dot, a 2-tick gap keeps the letter open
      press(3);
      ticks(2);
      press(2);
      ticks(15);
      take("bnd", 5'b00010, 3'd2, 1'b0, 1'b0);
      end_word("bnd");
      // consumer stalls across two letters
      bus.sym_ready = 1'b0;
      press(1);
      ticks(5);
      check("stall_valid", 32'(bus.sym_valid), 1);
      check("stall_len", 32'(bus.sym_len), 1);
      check("stall_ovr0", 32'(overrun), 0);
      press(3);
      ticks(15);
      check("ovr_set", 32'(overrun), 1);
      check("ovr_valid", 32'(bus.sym_valid), 1);
      check("ovr_code", 32'(bus.sym_code), 0);
      check("ovr_len", 32'(bus.sym_len), 1);
      bus.sym_ready = 1'b1;
      cyc(3);
      take("ovr", 5'b00000, 3'd1, 1'b0, 1'b0);
      check("ovr_left", 32'(q.size()), 0);
      check("ovr_drain", 32'(bus.sym_valid), 0);
      check("ovr_sticky", 32'(overrun), 1);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      check_reset_outputs("rst2");
      // reset in the middle of the third press of a letter
      press(1);
      ticks(1);
      press(3);
      ticks(1);
      key_down();
      ticks(1);
      reset = 1'b1;
      cyc(2);
      check_reset_outputs("rst3");
      reset = 1'b0;
      cyc(2);
      press(1);
      ticks(15);
      take("E", 5'b00000, 3'd1, 1'b0, 1'b0);
      end_word("E");
      // 'T' followed by a long idle
      press(4);
      ticks(20);
      take("T", 5'b00001, 3'd1, 1'b0, 1'b0);
      end_word("T");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
